// File: rtl/button_event.sv
// rtl/button_event.sv - classifies the debounced button level into press/short/long/repeat pulses
module button_event #(
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned LONG_CYCLES   = 12000000,
  parameter int unsigned REPEAT_CYCLES = 2400000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic button_in,
  input  logic repeat_en_in,
  output logic press_out,
  output logic short_out,
  output logic long_out,
  output logic repeat_out,
  output logic held_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_prev;
  logic             rise;
  logic             press_d, short_d, long_d, repeat_d;

  assign rise = btn_q & ~btn_prev;

  // Both input flops reset high so a button held through reset is not seen as a new press.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      btn_q    <= 1'b1;
      btn_prev <= 1'b1;
    end else begin
      btn_q    <= button_in;
      btn_prev <= btn_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        // Release is checked before the threshold so a release on the terminal cycle is short.
        if (!btn_q) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == LONG_TERM) begin
          long_d  = 1'b1;
          cnt_d   = '0;
          state_d = LONG;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LONG: begin
        if (!btn_q) begin
          state_d = IDLE;
        end else if (!repeat_en_in) begin
          cnt_d = '0;
        end else if (cnt_q == REPEAT_TERM) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      press_out  <= 1'b0;
      short_out  <= 1'b0;
      long_out   <= 1'b0;
      repeat_out <= 1'b0;
      held_out   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      press_out  <= press_d;
      short_out  <= short_d;
      long_out   <= long_d;
      repeat_out <= repeat_d;
      held_out   <= (state_d != IDLE);
    end
  end

endmodule

// File: doc/button_event.md
# button_event

Classifies the debounced push-button level into single-cycle events for the DDS control logic: press, short press, long press, and auto-repeat while held. It sits directly downstream of the button debouncer and consumes its stable level output. Its pulses drive the frequency/step-select control in the same clock domain.

## Interface
- `CNT_W`, default 24: width of the internal hold counter.
- `LONG_CYCLES`, default 12000000: hold duration, in clocks after `press_out`, that qualifies as a long press. Valid range is 2 ≤ value < 2^CNT_W.
- `REPEAT_CYCLES`, default 2400000: period of `repeat_out` while the button is held past long press. Valid range is 1 ≤ value < 2^CNT_W.
- `clk_in`  input  1  system clock. The block uses one clock only.
- `rst_in`  input  1  reset, synchronous and active-high.
- `button_in`  input  1  debounced button level from the debouncer; 1 means pressed.
- `repeat_en_in`  input  1  enables auto-repeat pulses in the long-hold state.
- `press_out`  output  1  one-cycle pulse on each accepted press.
- `short_out`  output  1  one-cycle pulse on release before the long threshold.
- `long_out`  output  1  one-cycle pulse when the long threshold is reached.
- `repeat_out`  output  1  one-cycle pulse every `REPEAT_CYCLES` clocks in the long-hold state.
- `held_out`  output  1  high while the FSM is in PRESSED or LONG.

## Operation
- **Input stage**
  - `button_in` is registered into `btn_q`.
  - `btn_q` is registered into `btn_prev`.
  - A rising edge is `btn_q & ~btn_prev`.
- **Reset**
  - state = IDLE, cnt = 0.
  - All outputs are 0.
  - `btn_q` and `btn_prev` are loaded to 1. A button held through reset is therefore ignored until it is released and pressed again.
- **Outputs**
  - All outputs are registered.
  - Pulse outputs default to 0 every cycle.
  - At most one pulse output is high in any cycle.
- **IDLE**
  - On a rising edge: `press_out` = 1, cnt ← 0, go to PRESSED.
  - Otherwise stay in IDLE.
  - `btn_q` = 1 without a rising edge does not produce a press.
- **PRESSED** (evaluated in this priority order)
  - `btn_q` = 0: `short_out` = 1, go to IDLE.
  - Else if cnt == LONG_CYCLES−1: `long_out` = 1, cnt ← 0, go to LONG.
  - Else cnt ← cnt+1.
- **LONG** (evaluated in this priority order)
  - `btn_q` = 0: go to IDLE with no pulse.
  - Else if `repeat_en_in` = 0: cnt ← 0.
  - Else if cnt == REPEAT_CYCLES−1: `repeat_out` = 1, cnt ← 0.
  - Else cnt ← cnt+1.
- **Counter**
  - cnt is CNT_W bits and unsigned.
  - It is compared for equality only. It never wraps, because the terminal compare always resets it.
- **`held_out`**
  - Registered as (next state ≠ IDLE).
  - It rises in the same cycle as `press_out`.
  - It falls in the cycle after the FSM first sees `btn_q` = 0.

## Timing
- **Press latency:** `button_in` first sampled high at edge E0 → `btn_q` = 1 after E0 → `press_out` high for exactly one cycle after edge E0+1.
- **Short release latency:** `button_in` sampled low at edge R0 → `short_out` (or LONG exit) after edge R0+1.
- **Long press:** `long_out` rises exactly LONG_CYCLES clocks after `press_out` rises, provided `btn_q` stays 1.
- **First repeat:** occurs REPEAT_CYCLES clocks after `long_out`, if `repeat_en_in` is held high. Subsequent repeats follow every REPEAT_CYCLES clocks.
- **Release on the terminal cycle:** `btn_q` = 0 in the same cycle cnt == LONG_CYCLES−1 → release wins. `short_out` fires and `long_out` does not.
- **Release on the repeat terminal cycle:** release wins and no `repeat_out` fires.
- **`repeat_en_in` deasserted mid-count:** the count restarts from 0. Reasserting it gives a full REPEAT_CYCLES period before the next pulse.
- **Reset mid-operation:**
  - Takes effect at the next edge, and every output is 0 after that edge.
  - Any pulse pending in that cycle is dropped.
- **Re-press:** a new press is accepted no earlier than 2 cycles after the release that returned the FSM to IDLE. `btn_prev` must see 0 first.

## Test plan
All scenarios use LONG_CYCLES = 8 and REPEAT_CYCLES = 3.
- **Short press:** reset, then `button_in` high for 5 cycles, then low.
  - `press_out` 1 cycle, 2 cycles after the rise.
  - `short_out` 1 cycle, 2 cycles after the fall.
  - `held_out` high from the `press_out` cycle through the cycle before `short_out` (both inclusive); low from the `short_out` cycle onward.
  - `long_out` never fires.
- **Long press with repeat:** `repeat_en_in` = 1, `button_in` high for 20 cycles.
  - `long_out` exactly 8 cycles after `press_out`.
  - `repeat_out` at +3 and +6 after `long_out`.
  - No `short_out` on release.
  - `held_out` low 2 cycles after the fall.
- **Boundary release:** release timed so `btn_q` = 0 on the cycle cnt = 7.
  - `short_out` fires and `long_out` never fires.
- **Repeat gating:** in LONG, drop `repeat_en_in` for 2 cycles, then raise it.
  - No `repeat_out` while it is low.
  - Next `repeat_out` exactly 3 cycles after it is reasserted.
- **Reset while held:** assert `rst_in` mid-LONG while the button stays high, then deassert.
  - All outputs 0 and no `press_out` while held.
  - Release and re-press → `press_out` 2 cycles after the re-press.
